data_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the datapath's load/store port and the backing data memory. Read hits return data combinationally in the same cycle, keeping single-cycle CPI. Read misses and all stores stall the core while a valid/ack transaction completes on the memory side. The block also performs byte/half/word lane selection and sign/zero extension from `funct3`, so the datapath sees a final 32-bit load result.

---
 rtl/data_cache.sv | 178 +++++++++++++++++
 tb/tb_data_cache.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with RV32I load/store lane handling.
// Define DCACHE_STATS_EN to add the hit_count/miss_count statistics ports.
module data_cache #(
  parameter int unsigned INDEX_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_funct3,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned TAG_W = 30 - INDEX_W;

  typedef enum logic [1:0] {IDLE, MISS, WRITE, WDONE} state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_store  [LINES];
  logic [31:0]        data_store [LINES];

  logic [1:0]         offset;
  logic [INDEX_W-1:0] index;
  logic [INDEX_W-1:0] q_index;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               wr_hit;
  logic [31:0]        line;
  logic [7:0]         sel_byte;
  logic [15:0]        sel_half;
  logic [31:0]        load_val;
  logic [3:0]         st_wstrb;
  logic [31:0]        st_wdata;

  assign offset   = cpu_addr[1:0];
  assign index    = cpu_addr[INDEX_W+1:2];
  assign tag      = cpu_addr[31:INDEX_W+2];
  assign q_index  = mem_addr[INDEX_W+1:2];
  assign hit      = valid[index] && (tag_store[index] == tag);
  assign line     = data_store[index];
  assign sel_byte = line[{offset, 3'b000} +: 8];
  assign sel_half = line[{offset[1], 4'b0000} +: 16];

  always_comb begin
    unique case (cpu_funct3)
      3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_val = {24'b0, sel_byte};
      3'b101:  load_val = {16'b0, sel_half};
      default: load_val = line;
    endcase
  end

  always_comb begin
    unique case (cpu_funct3[1:0])
      2'b00: begin
        st_wstrb = 4'b0001 << offset;
        st_wdata = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        st_wstrb = 4'b0011 << {offset[1], 1'b0};
        st_wdata = {2{cpu_wdata[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = cpu_wdata;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    cpu_rdata = '0;
    unique case (state)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            stall     = 1'b1;
            state_nxt = WRITE;
          end else if (hit) begin
            cpu_rdata = load_val;
          end else begin
            stall     = 1'b1;
            state_nxt = MISS;
          end
        end
      end
      MISS: begin
        stall = 1'b1;
        if (mem_ack) state_nxt = IDLE;
      end
      WRITE: begin
        stall = 1'b1;
        if (mem_ack) state_nxt = WDONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_req = (state == MISS) || (state == WRITE);
  assign mem_we  = (state == WRITE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      valid     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      wr_hit    <= 1'b0;
    end else begin
      state <= state_nxt;
      // Capture only on the cycle that leaves IDLE for the memory side.
      if (state == IDLE && cpu_req && (cpu_we || !hit)) begin
        mem_addr <= {cpu_addr[31:2], 2'b00};
        if (cpu_we) begin
          mem_wdata <= st_wdata;
          mem_wstrb <= st_wstrb;
          wr_hit    <= hit;
        end
      end
      if (state == MISS && mem_ack) valid[q_index] <= 1'b1;
    end
  end

  // Line storage has no reset; a reset edge still suppresses any pending fill or merge.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == MISS && mem_ack) begin
        tag_store[q_index]  <= mem_addr[31:INDEX_W+2];
        data_store[q_index] <= mem_rdata;
      end
      if (state == WRITE && mem_ack && wr_hit) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (mem_wstrb[i]) data_store[q_index][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic after_miss;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      after_miss <= 1'b0;
    end else begin
      after_miss <= (state == MISS);
      if (state == IDLE && cpu_req && !cpu_we) begin
        if (!hit) miss_count <= miss_count + 32'd1;
        else if (!after_miss) hit_count <= hit_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus randomized accesses against a
// word-level memory/residency model. Define DCACHE_STATS_EN to also check the statistics ports.
module tb_data_cache;

  localparam int unsigned IW = 8;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  data_cache #(.INDEX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_funct3(cpu_funct3),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: backing memory (word address -> word) and which word address each index holds.
  // Write-through keeps a resident line equal to memory, so line data comes from the memory model.
  logic [31:0] mem_m [int unsigned];
  int unsigned cache_line [int unsigned];
  int unsigned exp_hits = 0;
  int unsigned exp_misses = 0;

  function automatic logic [31:0] mem_word(input int unsigned wa);
    if (mem_m.exists(wa)) return mem_m[wa];
    return (wa * 32'h9E37_79B1) ^ 32'h0123_4567;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int unsigned idx = (a >> 2) % (1 << IW);
    return cache_line.exists(idx) && cache_line[idx] == (a >> 2);
  endfunction

  function automatic logic [31:0] load_ref(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    int unsigned b = (w >> (8 * a[1:0])) & 32'hFF;
    int unsigned h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd1: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_cycle(input logic stray_ack);
    @(negedge clk);
    cpu_req = 1'b0; mem_ack = stray_ack; mem_rdata = $urandom;
    #1;
    check("idle_stall", stall, 1'b0);
    check("idle_rdata", cpu_rdata, 32'h0);
    check("idle_memreq", mem_req, 1'b0);
  endtask

  // One complete core access; this task also plays the memory, acking lat cycles after mem_req rises.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int unsigned lat);
    bit          exp_hit;
    int unsigned stalls;
    int unsigned size;
    int unsigned base;
    logic [3:0]  strb;
    logic [31:0] wl;
    logic [31:0] word;
    int unsigned wa;
    wa      = a >> 2;
    exp_hit = model_hit(a);
    size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    base    = (a[1:0] / size) * size;
    for (int i = 0; i < 4; i++) begin
      strb[i] = (i >= base) && (i < base + size);
      wl[8*i +: 8] = wd[8*(i % size) +: 8];
    end
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_funct3 = f3; cpu_addr = a; cpu_wdata = wd;
    mem_ack = 1'b0; mem_rdata = $urandom;
    #1;
    if (!we && exp_hit) begin
      exp_hits++;
      check("hit_stall", stall, 1'b0);
      check("hit_rdata", cpu_rdata, load_ref(f3, a, mem_word(wa)));
      check("hit_memreq", mem_req, 1'b0);
    end else begin
      if (!we) exp_misses++;
      check("req_stall", stall, 1'b1);
      stalls = 1;
      for (int unsigned n = 0; n <= lat; n++) begin
        @(negedge clk);
        mem_ack   = (n == lat);
        mem_rdata = (n == lat && !we) ? mem_word(wa) : $urandom;
        #1;
        check("txn_memreq", mem_req, 1'b1);
        check("txn_memwe", mem_we, we);
        check("txn_addr", mem_addr, {a[31:2], 2'b00});
        if (we) begin
          check("txn_wstrb", {28'b0, mem_wstrb}, {28'b0, strb});
          check("txn_wdata", mem_wdata, wl);
        end
        if (stall) stalls++;
      end
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
      #1;
      check("done_memreq", mem_req, 1'b0);
      check("done_stall", stall, 1'b0);
      check("stall_cycles", stalls, lat + 2);
      if (we) begin
        word = mem_word(wa);
        for (int i = 0; i < 4; i++) if (strb[i]) word[8*i +: 8] = wl[8*i +: 8];
        mem_m[wa] = word;
      end else begin
        cache_line[(a >> 2) % (1 << IW)] = wa;
        check("fill_rdata", cpu_rdata, load_ref(f3, a, mem_word(wa)));
      end
    end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic check_stats();
    check("hit_count", hit_count, exp_hits);
    check("miss_count", miss_count, exp_misses);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ld_f3 [8];
    logic [31:0] ra;
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_funct3 = 3'd0;
    cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_memreq", mem_req, 1'b0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_wstrb", {28'b0, mem_wstrb}, 32'h0);
`ifdef DCACHE_STATS_EN
    check_stats();
`endif
    rst = 1'b1;

    // Cold miss then hit.
    mem_m[32'h100 >> 2] = 32'hDEAD_BEEF;
    access(1'b0, 3'd2, 32'h0000_0100, 32'h0, 2);
    access(1'b0, 3'd2, 32'h0000_0100, 32'h0, 0);
    check("coldmiss_hit_val", cpu_rdata, 32'hDEAD_BEEF);

    // Store hit writes the line, then extension checks.
    access(1'b1, 3'd2, 32'h0000_0100, 32'h80FF_7F01, 1);
    access(1'b0, 3'd0, 32'h0000_0102, 32'h0, 0);
    check("lb_off2", cpu_rdata, 32'hFFFF_FFFF);
    access(1'b0, 3'd4, 32'h0000_0103, 32'h0, 0);
    check("lbu_off3", cpu_rdata, 32'h0000_0080);
    access(1'b0, 3'd1, 32'h0000_0100, 32'h0, 0);
    check("lh_off0", cpu_rdata, 32'h0000_7F01);
    access(1'b0, 3'd5, 32'h0000_0102, 32'h0, 0);
    check("lhu_off2", cpu_rdata, 32'h0000_80FF);

    // SB hit merges one byte.
    access(1'b1, 3'd0, 32'h0000_0101, 32'h0000_00AB, 1);
    access(1'b0, 3'd2, 32'h0000_0100, 32'h0, 0);
    check("sb_merge", cpu_rdata, 32'h80FF_AB01);

    // Store miss does not allocate.
    access(1'b1, 3'd2, 32'h0000_2000, 32'h1234_5678, 0);
    access(1'b0, 3'd2, 32'h0000_2000, 32'h0, 1);
    check("store_miss_val", cpu_rdata, 32'h1234_5678);

    // Conflict eviction on the same index.
    access(1'b0, 3'd2, 32'h0000_0500, 32'h0, 0);
    access(1'b0, 3'd2, 32'h0000_0100, 32'h0, 3);
    check("evict_reload", cpu_rdata, 32'h80FF_AB01);

    // Stray ack with no transaction outstanding.
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // Randomized traffic over a few indices and tags to force hits, misses and conflicts.
    for (int unsigned k = 0; k < 150; k++) begin
      ra = ($urandom_range(0, 2) << (IW + 2)) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) idle_cycle($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        access(1'b1, $urandom_range(0, 2), ra, $urandom, $urandom_range(0, 3));
      else
        access(1'b0, ld_f3[$urandom_range(0, 7)], ra, 32'h0, $urandom_range(0, 3));
    end
`ifdef DCACHE_STATS_EN
    check_stats();
`endif

    // Reset while a miss is outstanding, with an ack arriving on the reset edge.
    access(1'b0, 3'd2, 32'h0000_0900, 32'h0, 0);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'd2; cpu_addr = 32'h0000_0D00;
    #1;
    check("rstmiss_stall", stall, 1'b1);
    @(negedge clk);
    #1;
    check("rstmiss_memreq", mem_req, 1'b1);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    rst = 1'b1; mem_ack = 1'b0; cpu_req = 1'b0;
    #1;
    check("rstmiss_memreq_drop", mem_req, 1'b0);
    check("rstmiss_stall_drop", stall, 1'b0);
    cache_line.delete();
    exp_hits = 0;
    exp_misses = 0;
`ifdef DCACHE_STATS_EN
    check_stats();
`endif
    access(1'b0, 3'd2, 32'h0000_0D00, 32'h0, 1);
    access(1'b0, 3'd2, 32'h0000_0900, 32'h0, 0);
    access(1'b0, 3'd2, 32'h0000_0900, 32'h0, 0);
`ifdef DCACHE_STATS_EN
    check_stats();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
